mult_div_unit: RTL

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file's two read ports in the execute stage. It accepts MULT/MULTU/DIV/DIVU with rs/rt operands, computes over WIDTH+1 cycles, and holds the results in HI/LO. HI/LO are read by MFHI/MFLO and written by MTHI/MTLO. The `busy` output drives the hazard logic, which stalls any HI/LO access while an operation is in flight.

---
 rtl/mult_div_if.sv | 30 +++
 rtl/mult_div_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mult_div_if.sv
// Execute-stage connection between the register-file read ports / hazard logic
// and the iterative multiply/divide unit.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    // Handshake: start is taken at an edge where busy=0 and cancel=0; busy then
    // stays high until the edge that writes HI/LO (done follows) or a cancel.
    modport master (
        output start, op, rs_data, rt_data, cancel, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, cancel, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide over
// magnitudes, sign fix-up in a final cycle, results held in HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mult_div_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        rs_mag = (!bus.op[0] && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
        rt_mag = (!bus.op[0] && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
        mul_sum = {1'b0, acc[WIDTH-1:0]} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        // acc[WIDTH] is always 0 between steps, so the top bit of the trial is a clean borrow.
        div_trial = {acc, mq[WIDTH-1]} - {2'b00, mcand};
        prod_raw = {acc[WIDTH-1:0], mq};
        prod_fix = (sign_a ^ sign_b) ? -prod_raw : prod_raw;
        quo_fix  = (sign_a ^ sign_b) ? -mq : mq;
        rem_fix  = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            mq     <= '0;
            mcand  <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                        is_div <= bus.op[1];
                        sign_a <= !bus.op[0] && bus.rs_data[WIDTH-1];
                        sign_b <= !bus.op[0] && bus.rt_data[WIDTH-1];
                        mq     <= rs_mag;
                        mcand  <= rt_mag;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                S_RUN: begin
                    if (bus.cancel) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (is_div) begin
                            acc <= div_trial[WIDTH+1] ? {acc[WIDTH-1:0], mq[WIDTH-1]}
                                                      : div_trial[WIDTH:0];
                            mq  <= {mq[WIDTH-2:0], ~div_trial[WIDTH+1]};
                        end else begin
                            acc <= {1'b0, mul_sum[WIDTH:1]};
                            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.cancel) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign dbg_state = state;
endmodule
